alu: RTL and testbench
======================

Name: alu

Overview:
MIPS-subset integer ALU for the CSC3050 CPU datapath. Decodes a 32-bit MIPS instruction word and operates on two 32-bit operand values (regA = rs value, regB = rt value). Produces a 32-bit result and three status flags (zero, negative, overflow). Outputs are registered, giving one cycle of latency.

Parameters:
- none (all widths fixed at 32-bit data and 3-bit flags)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- instruction  input  32  MIPS instruction word: opcode [31:26], rs [25:21], rt [20:16], shamt [10:6], funct [5:0], imm [15:0]
- regA  input  32  first operand (rs value; also the shifted value for shifts)
- regB  input  32  second operand (rt value; shift amount for variable shifts)
- result  output  32  registered ALU result
- flags  output  3  registered flags: [2]=zero, [1]=negative, [0]=overflow

Behaviour:
- Reset: while rst_n=0 (asynchronous), result=0 and flags=3'b000.
- Each rising clk: result and flags load the combinational value for the current inputs. Latency is 1 cycle and throughput is 1 operation per cycle. There is no handshake and no state machine.
- Immediates: sext(imm) is used for ADDI, ADDIU, SLTI, SLTIU, LW, SW. zext(imm) is used for ANDI, ORI, XORI.
- R-type operations (opcode 000000, selected by funct):
  - ADD 100000, ADDU 100001: A+B.
  - SUB 100010, SUBU 100011: A−B.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise; NOR = ~(A|B).
  - SLT 101010: signed A<B. SLTU 101011: unsigned A<B.
  - SLL 000000, SRL 000010, SRA 000011: shift regA by shamt.
  - SLLV 000100, SRLV 000110, SRAV 000111: shift regA by regB[4:0].
- I-type operations:
  - ADDI 001000, ADDIU 001001: A+sext.
  - ANDI 001100, ORI 001101, XORI 001110: A op zext.
  - SLTI 001010: signed compare vs sext. SLTIU 001011: unsigned compare vs sext.
  - BEQ 000100, BNE 000101: result = A−B.
  - LW 100011, SW 101011: result = A+sext (effective address).
- SLT family result is {31'b0, less}.
- Arithmetic wraps modulo 2^32.
- SRA and SRAV replicate bit 31; a shift by 0 returns regA unchanged.
- Overflow flag: set only for ADD, ADDI and SUB on signed overflow (operands of equal sign yielding a differently signed sum; for SUB, operands of differing sign where the sign of the result differs from A). Otherwise 0. ADDU, ADDIU and SUBU never set it.
- Zero flag: set only for BEQ and BNE when A−B==0; otherwise 0.
- Negative flag: set only for the SLT family when the comparison is true; otherwise 0.
- On overflow, result still carries the wrapped sum/difference.
- Unsupported opcode/funct: result=0, flags=0.
- Reset asserted mid-operation clears the outputs immediately. The first edge after release loads a fresh result.

Optional Feature:
- ALU_LUI_EN defined: adds LUI (opcode 001111), result = {imm,16'b0}, flags = 0.
- Without ALU_LUI_EN: opcode 001111 is treated as unsupported (result 0, flags 0).

Decomposition:
- alu_pkg holds:
  - opcode and funct localparams for every instruction above
  - flag bit indices (FLAG_ZERO=2, FLAG_NEG=1, FLAG_OVF=0)
  - an operation enum produced by decode
- One sub-module, alu_shifter: logical-left, logical-right and arithmetic-right barrel shifter on 32-bit data with a 5-bit amount.
- Decode, arithmetic, the flags and the output register live in alu.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1 -> result 0x80000000, flags 001 after one clk. ADDU with the same operands -> 0x80000000, flags 000.
- SUB, A=−30, B=−31 -> result 1, flags 000. ADDIU, A=0x7FFFFFFF, imm=0xFFFF -> 0x7FFFFFFE, flags 000.
- BEQ, A=10, B=10 -> result 0, flags 100. BNE, A=10, B=20 -> result 0xFFFFFFF6, flags 000.
- SLT, A=10, B=20 -> result 1, flags 010. SLTIU, A=20, imm=2 -> result 0, flags 000. SLTU, A=0xFFFFFFFF, B=1 -> result 0, flags 000.
- Shifts:
  - SLL shamt=10, A=5 -> 0x1400.
  - SRL shamt=10, A=1024 -> 1.
  - SRA shamt=10, A=0xF0000000 -> 0xFFFC0000.
  - SRAV, B=2, A=0xF0000000 -> 0xFC000000.
- Logic: ANDI A=0xC, imm=0xC -> 0xC. NOR A=0xC, B=0xA -> 0xFFFFFFF1. Reset: assert rst_n=0 between clock edges -> result and flags go to 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS-subset ALU: opcodes, funct codes, flag bit
// positions and the decoded operation / shifter-mode enums.
package alu_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic [4:0] {
    OP_NONE,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
    OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
    OP_BRANCH, OP_MEM, OP_LUI
  } op_t;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath (master) and the ALU (slave).
interface alu_if;
  logic [31:0] instruction;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (output instruction, regA, regB, input result, flags);
  modport slave  (input instruction, regA, regB, output result, flags);
endinterface

// File: rtl/alu_shifter.sv
// Five-stage log barrel shifter: logical left, logical right, arithmetic right.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [4:0]  amount,
  input  shift_t      kind,
  output logic [31:0] data_out
);

  logic [31:0] stage [0:5];
  logic        left;
  logic        fill;

  assign left     = (kind == SH_LL);
  assign fill     = (kind == SH_RA) & data_in[31];
  assign stage[0] = data_in;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [31:0] moved;
      assign moved = left ? {stage[gi][31-SH:0], {SH{1'b0}}}
                          : {{SH{fill}}, stage[gi][31:SH]};
      assign stage[gi+1] = amount[gi] ? moved : stage[gi];
    end
  endgenerate

  assign data_out = stage[5];

endmodule

// File: rtl/alu.sv
// MIPS-subset ALU: decode, arithmetic/logic, flags, one-cycle output register.
// Define ALU_LUI_EN to add LUI (opcode 001111); otherwise it decodes as unsupported.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic        unused_fields;

  op_t         op;
  logic [31:0] b_op;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        lt_s;
  logic        lt_u;
  shift_t      shift_kind;
  logic [4:0]  shift_amt;
  logic [31:0] shift_out;

  logic [31:0] result_d, result_q;
  logic [2:0]  flags_d,  flags_q;

  assign opcode        = bus.instruction[31:26];
  assign funct         = bus.instruction[5:0];
  assign shamt         = bus.instruction[10:6];
  assign imm           = bus.instruction[15:0];
  assign imm_s         = {{16{imm[15]}}, imm};
  assign imm_z         = {16'b0, imm};
  assign unused_fields = ^bus.instruction[25:16];

  always_comb begin
    op = OP_NONE;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD:  op = OP_ADD;
          FN_ADDU: op = OP_ADDU;
          FN_SUB:  op = OP_SUB;
          FN_SUBU: op = OP_SUBU;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_XOR:  op = OP_XOR;
          FN_NOR:  op = OP_NOR;
          FN_SLT:  op = OP_SLT;
          FN_SLTU: op = OP_SLTU;
          FN_SLL:  op = OP_SLL;
          FN_SRL:  op = OP_SRL;
          FN_SRA:  op = OP_SRA;
          FN_SLLV: op = OP_SLLV;
          FN_SRLV: op = OP_SRLV;
          FN_SRAV: op = OP_SRAV;
          default: op = OP_NONE;
        endcase
      end
      OPC_ADDI:         op = OP_ADDI;
      OPC_ADDIU:        op = OP_ADDIU;
      OPC_ANDI:         op = OP_ANDI;
      OPC_ORI:          op = OP_ORI;
      OPC_XORI:         op = OP_XORI;
      OPC_SLTI:         op = OP_SLTI;
      OPC_SLTIU:        op = OP_SLTIU;
      OPC_BEQ, OPC_BNE: op = OP_BRANCH;
      OPC_LW, OPC_SW:   op = OP_MEM;
`ifdef ALU_LUI_EN
      OPC_LUI:          op = OP_LUI;
`endif
      default:          op = OP_NONE;
    endcase
  end

  // Second operand: SLTIU compares against the sign-extended immediate too.
  always_comb begin
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_MEM: b_op = imm_s;
      OP_ANDI, OP_ORI, OP_XORI:                     b_op = imm_z;
      default:                                      b_op = bus.regB;
    endcase
  end

  assign sum     = bus.regA + b_op;
  assign diff    = bus.regA - b_op;
  assign add_ovf = (bus.regA[31] == b_op[31]) && (sum[31]  != bus.regA[31]);
  assign sub_ovf = (bus.regA[31] != b_op[31]) && (diff[31] != bus.regA[31]);
  assign lt_s    = $signed(bus.regA) < $signed(b_op);
  assign lt_u    = bus.regA < b_op;

  always_comb begin
    case (op)
      OP_SLL, OP_SLLV: shift_kind = SH_LL;
      OP_SRL, OP_SRLV: shift_kind = SH_RL;
      default:         shift_kind = SH_RA;
    endcase
    case (op)
      OP_SLLV, OP_SRLV, OP_SRAV: shift_amt = bus.regB[4:0];
      default:                   shift_amt = shamt;
    endcase
  end

  alu_shifter u_shifter (
    .data_in  (bus.regA),
    .amount   (shift_amt),
    .kind     (shift_kind),
    .data_out (shift_out)
  );

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    case (op)
      OP_ADD, OP_ADDI: begin
        result_d          = sum;
        flags_d[FLAG_OVF] = add_ovf;
      end
      OP_ADDU, OP_ADDIU, OP_MEM: result_d = sum;
      OP_SUB: begin
        result_d          = diff;
        flags_d[FLAG_OVF] = sub_ovf;
      end
      OP_SUBU: result_d = diff;
      OP_BRANCH: begin
        result_d           = diff;
        flags_d[FLAG_ZERO] = (diff == 32'd0);
      end
      OP_AND, OP_ANDI: result_d = bus.regA & b_op;
      OP_OR,  OP_ORI:  result_d = bus.regA | b_op;
      OP_XOR, OP_XORI: result_d = bus.regA ^ b_op;
      OP_NOR:          result_d = ~(bus.regA | b_op);
      OP_SLT, OP_SLTI: begin
        result_d          = {31'b0, lt_s};
        flags_d[FLAG_NEG] = lt_s;
      end
      OP_SLTU, OP_SLTIU: begin
        result_d          = {31'b0, lt_u};
        flags_d[FLAG_NEG] = lt_u;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV: result_d = shift_out;
`ifdef ALU_LUI_EN
      OP_LUI: result_d = {imm, 16'b0};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: table of hand-computed results plus reset
// and back-to-back sequences.
module tb_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

`ifdef ALU_LUI_EN
  localparam logic [31:0] LUI_EXP = 32'h1234_0000;
`else
  localparam logic [31:0] LUI_EXP = 32'h0000_0000;
`endif

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sa);
    return {6'b000000, 5'd1, 5'd2, 5'd3, sa, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd1, 5'd2, imm};
  endfunction

  task automatic add_vec(input string n, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.name = n; v.instr = ins; v.a = a; v.b = b; v.res = r; v.flg = f;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] exp_r, input logic [2:0] exp_f);
    checks++;
    if (bus.result !== exp_r || bus.flags !== exp_f) begin
      errors++;
      $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
               n, bus.result, bus.flags, exp_r, exp_f);
    end else begin
      $display("ok   %s: result=%h flags=%b", n, bus.result, bus.flags);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.instruction = ins;
    bus.regA        = a;
    bus.regB        = b;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instruction = rt(6'b100000, 5'd0);
    bus.regA        = 32'h7FFF_FFFF;
    bus.regB        = 32'h1;

    add_vec("ADD ovf",       rt(6'b100000, 5'd0), 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b001);
    add_vec("ADDU",          rt(6'b100001, 5'd0), 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b000);
    add_vec("SUB -30--31",   rt(6'b100010, 5'd0), 32'hFFFF_FFE2, 32'hFFFF_FFE1, 32'h1,         3'b000);
    add_vec("SUB ovf",       rt(6'b100010, 5'd0), 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 3'b001);
    add_vec("SUBU wrap",     rt(6'b100011, 5'd0), 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 3'b000);
    add_vec("ADD to zero",   rt(6'b100000, 5'd0), 32'h1,         32'hFFFF_FFFF, 32'h0,         3'b000);
    add_vec("ADDIU",         it(6'b001001, 16'hFFFF), 32'h7FFF_FFFF, 32'h0,     32'h7FFF_FFFE, 3'b000);
    add_vec("ADDI ovf",      it(6'b001000, 16'h0001), 32'h7FFF_FFFF, 32'h0,     32'h8000_0000, 3'b001);
    add_vec("ADDI neg imm",  it(6'b001000, 16'hFFFF), 32'h5,         32'h0,     32'h4,         3'b000);
    add_vec("BEQ equal",     it(6'b000100, 16'h0000), 32'd10,        32'd10,    32'h0,         3'b100);
    add_vec("BNE 10-20",     it(6'b000101, 16'h0000), 32'd10,        32'd20,    32'hFFFF_FFF6, 3'b000);
    add_vec("BEQ 5-3",       it(6'b000100, 16'h0000), 32'd5,         32'd3,     32'h2,         3'b000);
    add_vec("SLT true",      rt(6'b101010, 5'd0), 32'd10,        32'd20,        32'h1,         3'b010);
    add_vec("SLT signed",    rt(6'b101010, 5'd0), 32'd1,         32'hFFFF_FFFF, 32'h0,         3'b000);
    add_vec("SLTU false",    rt(6'b101011, 5'd0), 32'hFFFF_FFFF, 32'h1,         32'h0,         3'b000);
    add_vec("SLTIU false",   it(6'b001011, 16'h0002), 32'd20,        32'h0,     32'h0,         3'b000);
    add_vec("SLTIU sext",    it(6'b001011, 16'hFFFF), 32'd5,         32'h0,     32'h1,         3'b010);
    add_vec("SLTI -1<0",     it(6'b001010, 16'h0000), 32'hFFFF_FFFF, 32'h0,     32'h1,         3'b010);
    add_vec("SLL 10",        rt(6'b000000, 5'd10), 32'd5,        32'h0,         32'h0000_1400, 3'b000);
    add_vec("SRL 10",        rt(6'b000010, 5'd10), 32'd1024,     32'h0,         32'h1,         3'b000);
    add_vec("SRA 10",        rt(6'b000011, 5'd10), 32'hF000_0000, 32'h0,        32'hFFFC_0000, 3'b000);
    add_vec("SLL 0",         rt(6'b000000, 5'd0),  32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 3'b000);
    add_vec("SRAV 2",        rt(6'b000111, 5'd0), 32'hF000_0000, 32'd2,         32'hFC00_0000, 3'b000);
    add_vec("SRAV 32->0",    rt(6'b000111, 5'd0), 32'hF000_0000, 32'd32,        32'hF000_0000, 3'b000);
    add_vec("SLLV 4",        rt(6'b000100, 5'd0), 32'h1,         32'd4,         32'h10,        3'b000);
    add_vec("SRLV 31",       rt(6'b000110, 5'd0), 32'h8000_0000, 32'd31,        32'h1,         3'b000);
    add_vec("AND",           rt(6'b100100, 5'd0), 32'hF0F0,      32'hFF00,      32'hF000,      3'b000);
    add_vec("OR",            rt(6'b100101, 5'd0), 32'hF0F0,      32'hFF00,      32'hFFF0,      3'b000);
    add_vec("XOR",           rt(6'b100110, 5'd0), 32'hF0F0,      32'hFF00,      32'h0FF0,      3'b000);
    add_vec("NOR",           rt(6'b100111, 5'd0), 32'hC,         32'hA,         32'hFFFF_FFF1, 3'b000);
    add_vec("ANDI",          it(6'b001100, 16'h000C), 32'hC,         32'h0,     32'hC,         3'b000);
    add_vec("ORI zext",      it(6'b001101, 16'h8000), 32'hF000_0000, 32'h0,     32'hF000_8000, 3'b000);
    add_vec("XORI zext",     it(6'b001110, 16'hFFFF), 32'hFFFF_FFFF, 32'h0,     32'hFFFF_0000, 3'b000);
    add_vec("LW addr",       it(6'b100011, 16'hFFFC), 32'h1000,      32'h0,     32'h0FFC,      3'b000);
    add_vec("SW addr",       it(6'b101011, 16'h0010), 32'h100,       32'h0,     32'h110,       3'b000);
    add_vec("bad opcode",    it(6'b111111, 16'h1234), 32'h5,         32'h6,     32'h0,         3'b000);
    add_vec("bad funct",     rt(6'b111111, 5'd3), 32'h5,         32'h6,         32'h0,         3'b000);
    add_vec("LUI",           it(6'b001111, 16'h1234), 32'h5,         32'h6,     LUI_EXP,       3'b000);

    // Reset state, checked while reset is held across edges.
    repeat (2) @(posedge clk);
    #1 check("reset hold", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // One vector per cycle: also exercises full throughput.
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].res, vecs[i].flg);
    end

    // Asynchronous reset between edges clears a nonzero output at once.
    drive(rt(6'b100000, 5'd0), 32'h7FFF_FFFF, 32'h1);
    @(posedge clk);
    #1 check("pre-reset ADD", 32'h8000_0000, 3'b001);
    #2 rst_n = 1'b0;
    #1 check("async reset", 32'h0, 3'b000);
    @(posedge clk);
    #1 check("reset over edge", 32'h0, 3'b000);
    drive(rt(6'b100010, 5'd0), 32'hFFFF_FFE2, 32'hFFFF_FFE1);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first after release", 32'h1, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
